// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_scan_ctrl_pkg: shared geometry and key-index helpers for the 4x4 keypad
package keypad_scan_ctrl_pkg;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;
  localparam int KEY_IDX_W = 4;

  function automatic logic [KEY_IDX_W-1:0] key_index(input int row, input int col);
    return KEY_IDX_W'(row * NUM_COLS + col);
  endfunction

  function automatic logic [KEY_IDX_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] m);
    lowest_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (m[i]) lowest_key = KEY_IDX_W'(i);
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_key_debounce.sv
// key_debounce: frame snapshot assembly and multi-frame debounce of the key map
module key_debounce
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_sample,
  input  logic [1:0]          i_col,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic [NUM_KEYS-1:0] o_state,
  output logic [NUM_KEYS-1:0] o_rise
);
  logic [NUM_KEYS-1:0] r_snap, r_prev, w_snap;
  logic [3:0]          r_stable, w_stable;
  logic                w_frame, w_upd;

  // merge this slot's rows into the snapshot and evaluate the debounce decision
  always_comb begin
    w_snap = r_snap;
    for (int r = 0; r < NUM_ROWS; r++) w_snap[key_index(r, int'(i_col))] = ~i_row[r];
    w_frame  = i_sample && (i_col == 2'd3);
    w_stable = (w_snap == r_prev) ? ((r_stable == 4'd15) ? 4'd15 : r_stable + 4'd1) : 4'd0;
    w_upd    = w_frame && (w_stable == 4'(DEBOUNCE_FRAMES)) && (w_snap != o_state);
    o_rise   = w_upd ? (w_snap & ~o_state) : '0;
  end

  // snapshot on every sample, debounce state on every frame end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_snap   <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      o_state  <= '0;
    end else begin
      if (i_sample) r_snap <= w_snap;
      if (w_frame) begin
        r_prev   <= w_snap;
        r_stable <= w_stable;
      end
      if (w_upd) o_state <= w_snap;
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with debounce and press-event queue
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic [NUM_COLS-1:0]  key_col,
  input  logic [NUM_ROWS-1:0]  key_row,
  output logic [NUM_KEYS-1:0]  key_state,
  output logic                 key_valid,
  output logic [KEY_IDX_W-1:0] key_code,
  input  logic                 key_ready,
  output logic                 key_overrun
);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_col, w_col_n;
  logic [NUM_ROWS-1:0] r_sync1, r_sync2;
  logic [NUM_KEYS-1:0] r_pending, w_rise, w_acc, w_left;
  logic                w_wrap;

  assign w_wrap  = r_cnt == CW'(SCAN_DIV - 1);
  assign w_col_n = r_col + 2'd1;
  assign w_acc   = (key_valid && key_ready) ? (16'd1 << key_code) : '0;
  assign w_left  = r_pending & ~w_acc;

  // two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_row;
      r_sync2 <= r_sync1;
    end
  end

  // slot counter and column drive; the column moves on the slot wrap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_col   <= '0;
      key_col <= 4'b1110;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) begin
        r_col   <= w_col_n;
        key_col <= ~(4'b0001 << w_col_n);
      end
    end
  end

  key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk      (clk),
    .resetn   (resetn),
    .i_sample (w_wrap),
    .i_col    (r_col),
    .i_row    (r_sync2),
    .o_state  (key_state),
    .o_rise   (w_rise)
  );

  // pending press set and offered event; an offered code is held until accepted
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pending   <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_overrun <= 1'b0;
    end else begin
      r_pending <= w_left | w_rise;
      if (|(w_rise & w_left)) key_overrun <= 1'b1;
      key_valid <= |w_left;
      if (!(key_valid && !key_ready)) key_code <= lowest_key(w_left);
    end
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed scenarios with random keys against a frame-level keypad model
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  key_col, key_row, key_code;
  logic [15:0] key_state;
  logic        key_valid, key_overrun;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] hist[$];
  logic [15:0] m_state = '0;
  logic [15:0] exp_pend = '0;
  logic        exp_ovr = 1'b0;
  int          exp_q[$];
  bit          held = 1'b0;
  logic [3:0]  held_code = '0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_col     (key_col),
    .key_row     (key_row),
    .key_state   (key_state),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_overrun (key_overrun)
  );

  function automatic logic [3:0] rows(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && p[r*4+c]) v[r] = 1'b0;
    return v;
  endfunction

  assign key_row = rows(pressed, key_col);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_end();
    int          run;
    logic [15:0] s, rise;
    s = pressed;
    run = 0;
    hist.push_back(s);
    for (int i = hist.size() - 1; i >= 0 && hist[i] == s; i--) run++;
    if (((run - 1 > 15) ? 15 : run - 1) == DF && s != m_state) begin
      rise = s & ~m_state;
      m_state = s;
      for (int b = 0; b < 16; b++)
        if (rise[b]) begin
          if (exp_pend[b]) exp_ovr = 1'b1;
          else begin
            exp_pend[b] = 1'b1;
            exp_q.push_back(b);
          end
        end
    end
    chk("key_state", key_state, m_state);
    chk("key_overrun", key_overrun, exp_ovr);
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk);
    cyc++;
    #1;
    ec = ~(4'b0001 << ((cyc / SD) % 4));
    chk("key_col", key_col, ec);
    if (cyc % FR == 0) frame_end();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      tick();
      while (cyc % FR != 0) tick();
    end
  endtask

  task automatic keys(input logic [15:0] p);
    pressed = p;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pressed = '0;
    key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    hist.delete();
    hist.push_back('0);
    m_state = '0;
    exp_pend = '0;
    exp_ovr = 1'b0;
    exp_q.delete();
  endtask

  // transfer scoreboard and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (resetn) begin
      if (held) begin
        chk("hold_valid", key_valid, 1);
        chk("hold_code", key_code, held_code);
      end
      if (key_valid && key_ready) begin
        chk("event_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("event_code", key_code, exp_q[0]);
          exp_pend[exp_q[0]] = 1'b0;
          void'(exp_q.pop_front());
        end
      end
      held = key_valid && !key_ready;
      held_code = key_code;
    end else held = 1'b0;
  end

  initial begin
    int a, b, k;
    logic [15:0] m;
    do_reset();
    chk("rst_col", key_col, 4'b1110);
    chk("rst_state", key_state, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_overrun", key_overrun, 0);

    repeat (10) begin
      frames(1);
      chk("idle_valid", key_valid, 0);
    end

    keys(16'h0200);
    frames(3);
    chk("sc2_state", key_state, 16'h0200);
    chk("sc2_latency", key_valid, 0);
    tick();
    chk("sc2_valid", key_valid, 1);
    chk("sc2_code", key_code, 9);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("sc2_drop", key_valid, 0);
    frames(1);
    keys('0);
    frames(4);
    chk("sc2_drained", exp_q.size(), 0);

    k = $urandom_range(15);
    keys(16'(1) << k);
    frames(1);
    keys('0);
    frames(1);
    keys(16'(1) << k);
    frames(2);
    chk("sc3_not_yet", key_state, 0);
    frames(1);
    chk("sc3_state", key_state, 16'(1) << k);
    key_ready = 1'b1;
    frames(1);
    key_ready = 1'b0;
    keys('0);
    frames(4);
    chk("sc3_drained", exp_q.size(), 0);

    a = $urandom_range(7);
    b = $urandom_range(15, 8);
    keys((16'(1) << a) | (16'(1) << b));
    frames(3);
    tick();
    chk("sc4_valid", key_valid, 1);
    chk("sc4_first", key_code, a);
    repeat (100) tick();
    chk("sc4_hold", key_code, a);
    key_ready = 1'b1;
    tick();
    chk("sc4_b2b_valid", key_valid, 1);
    chk("sc4_second", key_code, b);
    tick();
    chk("sc4_empty", key_valid, 0);
    frames(1);
    keys('0);
    frames(4);
    key_ready = 1'b0;
    chk("sc4_drained", exp_q.size(), 0);

    k = $urandom_range(15);
    keys(16'(1) << k);
    frames(4);
    keys('0);
    frames(4);
    keys(16'(1) << k);
    frames(4);
    chk("sc5_overrun", key_overrun, 1);
    chk("sc5_valid", key_valid, 1);
    chk("sc5_code", key_code, k);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("sc5_single", key_valid, 0);
    chk("sc5_drained", exp_q.size(), 0);
    keys('0);
    frames(4);

    m = 16'($urandom) | 16'h0001;
    keys(m);
    frames(4);
    repeat (7) tick();
    chk("sc6_pending", key_valid, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("sc6_valid", key_valid, 0);
    chk("sc6_state", key_state, 0);
    chk("sc6_col", key_col, 4'b1110);
    chk("sc6_overrun", key_overrun, 0);
    do_reset();
    frames(4);
    chk("sc6_idle_valid", key_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
